capture_write_controller: RTL and testbench
===========================================

// Module: capture_write_controller
// PURPOSE
//  Upstream stage of the sample-memory write organizer: generates the circular write address and
//  write-enable strobe for one capture. Handles pre-trigger fill, trigger arm, post-trigger count
//  and completion. Latches the channel mode per capture; the latched mode and address drive the
//  organizer, which maps them onto the 4 x 8192 x 1 bank WE/datain.
// PARAMETERS
//  ADDR_W      16    write address width (4 banks x 8192 = 32768 locations)
//  BANK_DEPTH  8192  locations per bank
//  CNT_W       16    width of pre/post sample counters
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  mode         in   2       0=single ch, 1=dual, 2=quad, 3=invalid; sampled only on accepted start
//  start        in   1       capture request, single-cycle pulse
//  abort        in   1       cancel capture, single-cycle pulse
//  sample_en    in   1       sample strobe from the sampling-clock divider
//  trigger      in   1       trigger-unit hit, qualified by sample_en
//  pre_count    in   CNT_W   samples to store before the trigger is accepted
//  post_count   in   CNT_W   samples to store after the trigger sample
//  mode_q       out  2       mode latched at start, fed to the organizer
//  write_address out ADDR_W  current write pointer, fed to the organizer
//  wr_en        out  1       write strobe; sample stored at write_address this cycle
//  trig_address out ADDR_W   address of the trigger sample
//  busy         out  1       high in PRE_FILL/ARMED/POST
//  done         out  1       high in DONE until the next start or abort
// BEHAVIOUR
//  - Reset: state=IDLE; write_address, trig_address, mode_q = 0; wr_en, busy, done = 0.
//  - Depth D = 32768 >> mode_q (32768 / 16384 / 8192). write_address wraps from D-1 to 0.
//  - wr_en = sample_en & busy (combinational). write_address is registered and increments
//    modulo D on the clock after each wr_en cycle.
//  - Counter loads are clamped to D-1, so post-trigger data never overwrites the trigger sample.
//  - FSM states and transitions:
//    IDLE: start with mode!=3 -> latch mode_q, pointer=0, load pre counter, go PRE_FILL.
//          start with mode==3 is ignored.
//    PRE_FILL: each wr_en decrements the pre counter; the wr_en taking it 1->0 goes to ARMED.
//          pre_count==0 makes PRE_FILL last exactly one cycle with no write, then ARMED.
//          trigger is ignored in this state.
//    ARMED: trigger & sample_en marks that cycle's written sample as the trigger sample
//          -> trig_address <= write_address, load post counter.
//          post_count==0 -> DONE, else POST.
//    POST: each wr_en decrements; the wr_en taking it 1->0 goes to DONE. trigger is ignored.
//    DONE: wr_en=0, done=1, pointer holds. start -> same entry as from IDLE (done cleared).
//  - trigger without sample_en is ignored. start while busy is ignored.
//  - abort has the highest priority in every state: next state IDLE, wr_en drops the next
//    cycle, done=0, write_address and trig_address hold.
//  - start and abort in the same cycle: abort wins.
//  - Async reset mid-capture forces the reset values immediately; there is no partial-capture state.
// TESTING
//  1 mode=2, pre=4, post=3, sample_en=1, trigger on 6th write -> addrs 0..8 written,
//    trig_address=5, done on cycle after write of addr 8.
//  2 mode=2, pre=8190, trigger late -> address wraps 8191->0. pre=9000 clamped to 8191.
//  3 mode=0, pre=0, post=40000, immediate trigger at addr 0 -> post clamped to 32767,
//    last write at 32767, trig sample intact.
//  4 sample_en every 3rd cycle, trigger asserted on non-strobe cycles
//    -> no trigger accepted, wr_en only on strobes.
//  5 abort mid-POST with simultaneous start -> IDLE, done=0, wr_en low next cycle;
//    later start restarts at addr 0.
//  6 start with mode=3 -> stays IDLE. rst pulse mid-PRE_FILL -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/capture_write_controller.sv
// Capture write controller: circular write pointer and write strobe for one capture,
// covering pre-trigger fill, trigger arm, post-trigger count and completion.
module capture_write_controller #(
   parameter int ADDR_W     = 16,
   parameter int BANK_DEPTH = 8192,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic              start,
   input  logic              abort,
   input  logic              sample_en,
   input  logic              trigger,
   input  logic [CNT_W-1:0]  pre_count,
   input  logic [CNT_W-1:0]  post_count,
   output logic [1:0]        mode_q,
   output logic [ADDR_W-1:0] write_address,
   output logic              wr_en,
   output logic [ADDR_W-1:0] trig_address,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_dbg_o
);

   localparam int unsigned TOTAL_DEPTH = 4 * BANK_DEPTH;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PRE_FILL = 3'd1,
      S_ARMED    = 3'd2,
      S_POST     = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [ADDR_W-1:0] trig_addr_q;
   logic              busy_q;
   logic              done_q;
   logic              pre_empty;
   logic [ADDR_W-1:0] addr_inc;

   // Highest valid address for a channel mode: depth is 32768 >> mode.
   function automatic logic [ADDR_W-1:0] last_addr(input logic [1:0] m);
      return ADDR_W'((TOTAL_DEPTH >> m) - 1);
   endfunction

   function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c,
                                                  input logic [ADDR_W-1:0] lim);
      if (32'(c) > 32'(lim)) begin
         return CNT_W'(lim);
      end
      return c;
   endfunction

   // A zero pre count spends one PRE_FILL cycle without storing anything.
   assign pre_empty     = (state_q == S_PRE_FILL) && (cnt_q == '0);
   assign wr_en         = sample_en & busy_q & ~pre_empty;
   assign addr_inc      = (wr_addr_q == last_addr(mode_q)) ? '0 : wr_addr_q + ADDR_W'(1);
   assign write_address = wr_addr_q;
   assign trig_address  = trig_addr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign state_dbg_o   = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wr_addr_q   <= '0;
         trig_addr_q <= '0;
         mode_q      <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (abort) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start && (mode != 2'd3)) begin
                  mode_q    <= mode;
                  wr_addr_q <= '0;
                  cnt_q     <= clamp_cnt(pre_count, last_addr(mode));
                  state_q   <= S_PRE_FILL;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
               end
            end
            S_PRE_FILL: begin
               if (cnt_q == '0) begin
                  state_q <= S_ARMED;
               end else if (sample_en) begin
                  wr_addr_q <= addr_inc;
                  cnt_q     <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= S_ARMED;
                  end
               end
            end
            S_ARMED: begin
               if (sample_en) begin
                  wr_addr_q <= addr_inc;
                  if (trigger) begin
                     trig_addr_q <= wr_addr_q;
                     if (post_count == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        cnt_q   <= clamp_cnt(post_count, last_addr(mode_q));
                        state_q <= S_POST;
                     end
                  end
               end
            end
            S_POST: begin
               if (sample_en) begin
                  wr_addr_q <= addr_inc;
                  cnt_q     <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_capture_write_controller.sv
// Bench for capture_write_controller: a capture-level model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_capture_write_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic        start;
   logic        abort;
   logic        sample_en;
   logic        trigger;
   logic [15:0] pre_count;
   logic [15:0] post_count;
   logic [1:0]  mode_q;
   logic [15:0] write_address;
   logic        wr_en;
   logic [15:0] trig_address;
   logic        busy;
   logic        done;
   logic [2:0]  state_dbg;

   capture_write_controller dut (
      .clk           (clk),
      .rst           (rst),
      .mode          (mode),
      .start         (start),
      .abort         (abort),
      .sample_en     (sample_en),
      .trigger       (trigger),
      .pre_count     (pre_count),
      .post_count    (post_count),
      .mode_q        (mode_q),
      .write_address (write_address),
      .wr_en         (wr_en),
      .trig_address  (trig_address),
      .busy          (busy),
      .done          (done),
      .state_dbg_o   (state_dbg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] wr_log[$];
   logic [15:0] exp_q[$];

   // Capture-level model: pointer, depth, remaining pre/post samples.
   int m_mode = 0, m_depth = 32768, m_addr = 0, m_trig = 0;
   int m_pre_left = 0, m_post_left = 0;
   bit m_busy = 0, m_done = 0, m_in_pre = 0, m_triggered = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   always @(negedge clk) begin
      bit exp_wr;
      int prev_addr;
      if (rst) begin
         m_mode = 0; m_depth = 32768; m_addr = 0; m_trig = 0;
         m_busy = 0; m_done = 0; m_in_pre = 0; m_triggered = 0;
      end
      exp_wr = sample_en && m_busy && !(m_in_pre && m_pre_left == 0);
      check("cyc_wr_en", 32'(wr_en), 32'(exp_wr));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_mode_q", 32'(mode_q), 32'(m_mode));
      check("cyc_write_address", 32'(write_address), 32'(m_addr));
      check("cyc_trig_address", 32'(trig_address), 32'(m_trig));
      if (wr_en === 1'b1) wr_log.push_back(write_address);
      if (!rst) begin
         if (abort) begin
            m_busy = 0;
            m_done = 0;
         end else if (!m_busy) begin
            if (start && mode != 2'd3) begin
               m_mode      = int'(mode);
               m_depth     = 32768 >> mode;
               m_addr      = 0;
               m_pre_left  = min_int(int'(pre_count), m_depth - 1);
               m_in_pre    = 1;
               m_triggered = 0;
               m_busy      = 1;
               m_done      = 0;
            end
         end else begin
            prev_addr = m_addr;
            if (exp_wr) m_addr = (m_addr + 1) % m_depth;
            if (m_in_pre) begin
               if (exp_wr) m_pre_left--;
               if (m_pre_left == 0) m_in_pre = 0;
            end else if (!m_triggered) begin
               if (trigger && sample_en) begin
                  m_trig      = prev_addr;
                  m_triggered = 1;
                  m_post_left = min_int(int'(post_count), m_depth - 1);
                  if (m_post_left == 0) begin m_busy = 0; m_done = 1; end
               end
            end else if (exp_wr) begin
               m_post_left--;
               if (m_post_left == 0) begin m_busy = 0; m_done = 1; end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] m, input int pre, input int post);
      mode       = m;
      pre_count  = pre[15:0];
      post_count = post[15:0];
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      for (int k = 0; k < max_cyc && done !== 1'b1; k++) step();
      check(name, 32'(done), 32'd1);
   endtask

   task automatic wait_addr(input int a, input int max_cyc, input string name);
      for (int k = 0; k < max_cyc && int'(write_address) != a; k++) step();
      check(name, 32'(write_address), 32'(a));
   endtask

   initial begin
      int base;
      int zeros;
      rst = 1'b1; mode = 2'd0; start = 1'b0; abort = 1'b0;
      sample_en = 1'b0; trigger = 1'b0; pre_count = '0; post_count = '0;
      step(); step();
      check("rst_write_address", 32'(write_address), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      step();

      // 1: quad mode, pre 4, post 3, trigger on the 6th write
      sample_en = 1'b1;
      base = wr_log.size();
      do_start(2'd2, 4, 3);
      wait_addr(5, 20, "t1_reach_addr5");
      trigger = 1'b1; step(); trigger = 1'b0;
      wait_done(20, "t1_done");
      check("t1_trig_address", 32'(trig_address), 32'd5);
      check("t1_write_count", 32'(wr_log.size() - base), 32'd9);
      for (int i = 0; i < 9; i++) exp_q.push_back(16'(i));
      for (int i = 0; i < 9 && base + i < wr_log.size(); i++)
         check("t1_write_seq", 32'(wr_log[base + i]), 32'(exp_q[i]));
      exp_q.delete();
      check("t1_ptr_after", 32'(write_address), 32'd9);

      // 2a: pre 8190, trigger after the pointer wraps
      base = wr_log.size();
      do_start(2'd2, 8190, 2);
      wait_addr(8191, 9000, "t2_reach_8191");
      step();
      wait_addr(2, 10, "t2_reach_2_wrapped");
      trigger = 1'b1; step(); trigger = 1'b0;
      wait_done(10, "t2_done");
      check("t2_trig_address", 32'(trig_address), 32'd2);
      check("t2_write_count", 32'(wr_log.size() - base), 32'd8197);
      if (wr_log.size() - base == 8197) begin
         check("t2_wrap_hi", 32'(wr_log[base + 8191]), 32'd8191);
         check("t2_wrap_lo", 32'(wr_log[base + 8192]), 32'd0);
         check("t2_last_write", 32'(wr_log[base + 8196]), 32'd4);
      end

      // 2b: pre 9000 clamped to 8191, trigger held, post 0
      base = wr_log.size();
      trigger = 1'b1;
      do_start(2'd2, 9000, 0);
      wait_done(9000, "t2b_done");
      trigger = 1'b0;
      check("t2b_trig_address", 32'(trig_address), 32'd8191);
      check("t2b_write_count", 32'(wr_log.size() - base), 32'd8192);
      check("t2b_ptr_after", 32'(write_address), 32'd0);

      // 3: single channel, pre 0, post 40000 clamped to 32767
      base = wr_log.size();
      trigger = 1'b1;
      do_start(2'd0, 0, 40000);
      step(); step();
      trigger = 1'b0;
      wait_done(33000, "t3_done");
      check("t3_trig_address", 32'(trig_address), 32'd0);
      check("t3_write_count", 32'(wr_log.size() - base), 32'd32768);
      if (wr_log.size() > base)
         check("t3_last_write", 32'(wr_log[wr_log.size() - 1]), 32'd32767);
      zeros = 0;
      for (int i = base; i < wr_log.size(); i++) if (wr_log[i] == 16'd0) zeros++;
      check("t3_trig_sample_writes", 32'(zeros), 32'd1);

      // 4: strobe every 3rd cycle, trigger only between strobes
      sample_en = 1'b0;
      base = wr_log.size();
      do_start(2'd1, 2, 1);
      for (int i = 0; i < 30; i++) begin
         sample_en = (i % 3 == 0);
         trigger   = (i % 3 != 0);
         step();
      end
      sample_en = 1'b0; trigger = 1'b0;
      check("t4_write_count", 32'(wr_log.size() - base), 32'd10);
      check("t4_ptr", 32'(write_address), 32'd10);
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_done", 32'(done), 32'd0);
      abort = 1'b1; step(); abort = 1'b0;
      check("t4_abort_busy", 32'(busy), 32'd0);

      // 5: abort with simultaneous start during POST
      sample_en = 1'b1;
      do_start(2'd2, 1, 10);
      step();
      trigger = 1'b1; step(); trigger = 1'b0;
      step(); step();
      mode = 2'd2; pre_count = 16'd3; abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_wr_en", 32'(wr_en), 32'd0);
      check("t5_ptr_hold", 32'(write_address), 32'd4);
      check("t5_trig_address", 32'(trig_address), 32'd1);
      step();
      do_start(2'd2, 3, 1);
      check("t5_restart_ptr", 32'(write_address), 32'd0);
      check("t5_restart_busy", 32'(busy), 32'd1);
      abort = 1'b1; step(); abort = 1'b0;

      // 6: invalid mode ignored, then reset mid-fill
      do_start(2'd3, 5, 5);
      check("t6_mode3_busy", 32'(busy), 32'd0);
      check("t6_mode3_mode_q", 32'(mode_q), 32'd2);
      do_start(2'd1, 100, 5);
      for (int i = 0; i < 5; i++) step();
      check("t6_fill_ptr", 32'(write_address), 32'd5);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_ptr", 32'(write_address), 32'd0);
      check("t6_rst_trig", 32'(trig_address), 32'd0);
      check("t6_rst_mode_q", 32'(mode_q), 32'd0);
      check("t6_rst_wr_en", 32'(wr_en), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_done", 32'(done), 32'd0);
      step();
      rst = 1'b0;
      step(); step();
      check("t6_post_rst_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
